// File: rtl/spi_pkg.sv
// spi_pkg: shared state type, data width and bit-order / edge-select helpers for the SPI slave.
// Latency: none (declarations and pure functions only).
// Backpressure: none.
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_CNT_W  = $clog2(SPI_DATA_W);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  typedef logic [SPI_DATA_W-1:0] spi_byte_t;

  // Sample edge is sclk rise when cpol == cphase, else fall; swapping rise/fall yields the shift edge.
  function automatic logic edge_sel(input logic cpol, input logic cphase,
                                    input logic rise, input logic fall);
    return (cpol == cphase) ? rise : fall;
  endfunction

  // Bit that goes out next on miso for the selected bit order.
  function automatic logic tx_head(input spi_byte_t b, input logic lsbfe);
    return lsbfe ? b[0] : b[SPI_DATA_W-1];
  endfunction

  // Transmit shift register after its head bit has been presented.
  function automatic spi_byte_t tx_next(input spi_byte_t b, input logic lsbfe);
    return lsbfe ? {1'b0, b[SPI_DATA_W-1:1]} : {b[SPI_DATA_W-2:0], 1'b0};
  endfunction

  // Receive shift register with one new mosi bit inserted.
  function automatic spi_byte_t rx_in(input spi_byte_t b, input logic bit_i, input logic lsbfe);
    return lsbfe ? {bit_i, b[SPI_DATA_W-1:1]} : {b[SPI_DATA_W-2:0], bit_i};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with rise/fall pulse detection on the synchronised level.
// Latency: STAGES PCLK to q_o, edge pulses one PCLK wide, combinational from the last two samples.
// Backpressure: none; edges are suppressed until the chain holds only real samples after reset.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic [STAGES:0]   live_q, live_d;

  // Shift the raw input down the chain, keep the previous synced level, and track chain fill.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
    live_d = {live_q[STAGES-1:0], 1'b1};
  end

  // Synchroniser and edge-history registers; reset level is the inactive bus value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      live_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      live_q <= live_d;
    end
  end

  // A level still held low after reset must not look like a fresh edge.
  assign q_o    = sync_q[STAGES-1];
  assign rise_o = live_q[STAGES] &  q_o & ~prev_q;
  assign fall_o = live_q[STAGES] & ~q_o &  prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI slave, modes 0-3, MSB/LSB first, one-byte tx holding register; optional sticky
// overrun flag under SPI_SLAVE_OVERRUN_EN. Latency: SYNC_STAGES+1 PCLK from an sclk edge to miso/rx.
// Backpressure: none; tx_load_i is dropped while the holding register is full, rx bytes are not held.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET_n,
  input  logic                  sclk_i,
  input  logic                  ss_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  input  logic                  cpol_i,
  input  logic                  cphase_i,
  input  logic                  lsbfe_i,
  input  logic [SPI_DATA_W-1:0] tx_data_i,
  input  logic                  tx_load_i,
  output logic                  tx_empty_o,
  output logic [SPI_DATA_W-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  input  logic                  ovr_clr_i
);

  localparam logic [SPI_CNT_W-1:0] CNT_LAST = SPI_CNT_W'(SPI_DATA_W - 1);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic ss_sync, ss_fall, ss_rise_unused;
  logic sample_pls, shift_pls, reload, byte_done, mosi_sync;

  spi_state_e            state_q, state_d;
  logic [SPI_CNT_W-1:0]  cnt_q, cnt_d;
  spi_byte_t             tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  spi_byte_t             hold_q, hold_d, rx_data_q, rx_data_d, load_byte;
  logic                  tx_empty_q, tx_empty_d, rx_valid_q, rx_valid_d, miso_q, miso_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(PCLK), .rst_n(PRESET_n), .d_i(sclk_i),
    .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(PCLK), .rst_n(PRESET_n), .d_i(ss_i),
    .q_o(ss_sync), .rise_o(ss_rise_unused), .fall_o(ss_fall)
  );

  assign mosi_sync  = mosi_sync_q[SYNC_STAGES-1];
  assign sample_pls = edge_sel(cpol_i, cphase_i, sclk_rise, sclk_fall);
  assign shift_pls  = edge_sel(cpol_i, cphase_i, sclk_fall, sclk_rise);
  // An empty holding register transmits zeros.
  assign load_byte  = tx_empty_q ? '0 : hold_q;

  // Frame FSM, shift registers, bit counter and holding-register bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    hold_d      = hold_q;
    tx_empty_d  = tx_empty_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    miso_d      = miso_q;
    reload      = 1'b0;
    byte_done   = 1'b0;
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          cnt_d      = '0;
          rx_shift_d = '0;
          reload     = 1'b1;
          // cphase 0 presents the first bit right away; cphase 1 waits for the first shift edge.
          if (cphase_i) begin
            tx_shift_d = load_byte;
          end else begin
            miso_d     = tx_head(load_byte, lsbfe_i);
            tx_shift_d = tx_next(load_byte, lsbfe_i);
          end
        end
      end
      default: begin
        if (ss_sync) begin
          // Deselect at any bit position drops the partial byte.
          state_d    = IDLE;
          cnt_d      = '0;
          rx_shift_d = '0;
        end else begin
          if (shift_pls) begin
            miso_d     = tx_head(tx_shift_q, lsbfe_i);
            tx_shift_d = tx_next(tx_shift_q, lsbfe_i);
          end
          if (sample_pls) begin
            rx_shift_d = rx_in(rx_shift_q, mosi_sync, lsbfe_i);
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              byte_done  = 1'b1;
              rx_data_d  = rx_shift_d;
              rx_valid_d = 1'b1;
              // Back-to-back byte: the next shift edge starts the freshly reloaded byte.
              if (!tx_empty_q) begin
                reload     = 1'b1;
                tx_shift_d = hold_q;
              end
            end
          end
        end
      end
    endcase
    if (reload) tx_empty_d = 1'b1;
    // A reload frees the register in the same cycle, so a coincident load is kept.
    if (tx_load_i && (tx_empty_q || reload)) begin
      hold_d     = tx_data_i;
      tx_empty_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      hold_q      <= '0;
      tx_empty_q  <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      mosi_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      hold_q      <= hold_d;
      tx_empty_q  <= tx_empty_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  assign miso_o     = miso_q;
  assign tx_empty_o = tx_empty_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = (state_q == ACTIVE);

`ifdef SPI_SLAVE_OVERRUN_EN
  logic ovr_q, ovr_d, pend_q, pend_d;

  // pend marks an unacknowledged byte in this frame; a second completion while pending sets overrun.
  always_comb begin
    ovr_d  = ovr_q;
    pend_d = pend_q;
    if (state_q == IDLE) pend_d = 1'b0;
    if (byte_done) begin
      if (pend_q) ovr_d = 1'b1;
      pend_d = 1'b1;
    end
    if (ovr_clr_i) begin
      ovr_d  = 1'b0;
      pend_d = 1'b0;
    end
  end

  // Overrun tracking registers.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      ovr_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_d;
      pend_q <= pend_d;
    end
  end

  assign overrun_o = ovr_q;
`else
  logic ovr_unused;
  assign ovr_unused = ovr_clr_i ^ byte_done;
  assign overrun_o  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: SPI master model driving the slave at PCLK/8 in all modes and bit orders.
// Expected rx bytes come from a queue of what the master sent; expected miso bytes are the loaded tx bytes.
// Directed cases for the listed scenarios, then randomized frames.
module tb_spi_slave_core;

`ifdef SPI_SLAVE_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic       PCLK = 1'b0;
  logic       PRESET_n, sclk_i, ss_i, mosi_i, cpol_i, cphase_i, lsbfe_i, tx_load_i, ovr_clr_i;
  logic [7:0] tx_data_i;
  logic       miso_o, tx_empty_o, rx_valid_o, busy_o, overrun_o;
  logic [7:0] rx_data_o;

  int         total = 0;
  int         bad = 0;
  int         rx_pulses = 0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] exp_rx[$];
  logic [7:0] mo_a[4];
  logic [7:0] tx_a[4];
  logic [7:0] got_a[4];
  bit         exp_ovr = 1'b0;

  always #5 PCLK = ~PCLK;

  spi_slave_core #(.SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .sclk_i(sclk_i), .ss_i(ss_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .cpol_i(cpol_i), .cphase_i(cphase_i), .lsbfe_i(lsbfe_i),
    .tx_data_i(tx_data_i), .tx_load_i(tx_load_i), .tx_empty_o(tx_empty_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .busy_o(busy_o),
    .overrun_o(overrun_o), .ovr_clr_i(ovr_clr_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #2;
  endtask

  function automatic int bit_pos(input int bt, input bit lsb);
    return lsb ? bt : 7 - bt;
  endfunction

  // Every received byte must be the next one the master sent, and no pulse may appear unexpectedly.
  always @(negedge PCLK) begin
    logic [7:0] e;
    if (PRESET_n === 1'b1 && rx_valid_o === 1'b1) begin
      rx_pulses++;
      if (exp_rx.size() == 0) begin
        chk("rx_unexpected_pulse", 32'(rx_valid_o), 32'd0);
      end else begin
        e = exp_rx.pop_front();
        last_rx = rx_data_o;
        chk("rx_data", 32'(rx_data_o), 32'(e));
      end
    end
  end

  task automatic pulse_clr();
    ovr_clr_i = 1'b1;
    tick(1);
    ovr_clr_i = 1'b0;
    tick(1);
  endtask

  // One master frame: mo_a/tx_a hold the bytes; abort_bits > 0 deselects after that many bits.
  task automatic run_frame(input bit cpol, input bit cpha, input bit lsb, input int nbytes,
                           input int abort_bits);
    int nbits;
    nbits = (abort_bits > 0) ? abort_bits : 8 * nbytes;
    cpol_i = cpol; cphase_i = cpha; lsbfe_i = lsb; sclk_i = cpol;
    tick(6);
    chk("idle_tx_empty", 32'(tx_empty_o), 32'd1);
    tx_data_i = tx_a[0]; tx_load_i = 1'b1;
    tick(1);
    tx_load_i = 1'b0;
    if (abort_bits == 0)
      for (int k = 0; k < nbytes; k++) exp_rx.push_back(mo_a[k]);
    for (int k = 0; k < 4; k++) got_a[k] = 8'h00;
    ss_i = 1'b0;
    if (!cpha) mosi_i = mo_a[0][bit_pos(0, lsb)];
    tick(6);
    fork
      begin
        for (int k = 1; k < nbytes; k++) begin
          int w;
          w = 0;
          while (tx_empty_o !== 1'b1 && w < 400) begin
            tick(1);
            w++;
          end
          if (w >= 400) chk("tx_empty_timeout", 32'(tx_empty_o), 32'd1);
          tx_data_i = tx_a[k]; tx_load_i = 1'b1;
          tick(1);
          tx_load_i = 1'b0;
        end
      end
      begin
        for (int i = 0; i < nbits; i++) begin
          int by, bt;
          by = i / 8; bt = i % 8;
          if (!cpha) begin
            got_a[by][bit_pos(bt, lsb)] = miso_o;
            sclk_i = ~sclk_i;
            tick(4);
            sclk_i = ~sclk_i;
            if (i + 1 < nbits) mosi_i = mo_a[(i + 1) / 8][bit_pos((i + 1) % 8, lsb)];
            tick(4);
          end else begin
            sclk_i = ~sclk_i;
            mosi_i = mo_a[by][bit_pos(bt, lsb)];
            tick(4);
            got_a[by][bit_pos(bt, lsb)] = miso_o;
            sclk_i = ~sclk_i;
            tick(4);
          end
        end
      end
    join
    tick(4);
    ss_i = 1'b1;
    tick(8);
    chk("busy_after_frame", 32'(busy_o), 32'd0);
    chk("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    if (abort_bits == 0)
      for (int k = 0; k < nbytes; k++) chk("miso_byte", 32'(got_a[k]), 32'(tx_a[k]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, nb, ab;
    bit cp, ch, lb;
    PRESET_n = 1'b0; sclk_i = 1'b0; ss_i = 1'b1; mosi_i = 1'b0;
    cpol_i = 1'b0; cphase_i = 1'b0; lsbfe_i = 1'b0;
    tx_data_i = 8'h00; tx_load_i = 1'b0; ovr_clr_i = 1'b0;
    tick(3);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_tx_empty", 32'(tx_empty_o), 32'd1);
    chk("rst_rx_data", 32'(rx_data_o), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    chk("rst_miso", 32'(miso_o), 32'd0);
    chk("rst_overrun", 32'(overrun_o), 32'd0);
    PRESET_n = 1'b1;
    tick(10);

    // Mode 0, MSB first.
    mo_a[0] = 8'hA5; tx_a[0] = 8'h3C; p0 = rx_pulses;
    run_frame(1'b0, 1'b0, 1'b0, 1, 0);
    chk("m0_pulses", 32'(rx_pulses - p0), 32'd1);
    chk("m0_rx", 32'(last_rx), 32'hA5);
    chk("m0_miso", 32'(got_a[0]), 32'h3C);

    // Mode 3, LSB first.
    mo_a[0] = 8'h81; tx_a[0] = 8'h7E; p0 = rx_pulses;
    run_frame(1'b1, 1'b1, 1'b1, 1, 0);
    chk("m3_rx", 32'(last_rx), 32'h81);
    chk("m3_miso", 32'(got_a[0]), 32'h7E);

    // Mode 1, two back-to-back bytes with a reload after the first empty flag.
    mo_a[0] = 8'h12; mo_a[1] = 8'h34; tx_a[0] = 8'h96; tx_a[1] = 8'hF0; p0 = rx_pulses;
    run_frame(1'b0, 1'b1, 1'b0, 2, 0);
    chk("b2b_pulses", 32'(rx_pulses - p0), 32'd2);
    chk("b2b_rx2", 32'(last_rx), 32'h34);
    chk("b2b_miso2", 32'(got_a[1]), 32'hF0);
    chk("b2b_overrun", 32'(overrun_o), 32'(OVR_EN));
    pulse_clr();
    chk("ovr_cleared", 32'(overrun_o), 32'd0);

    // Deselect after 5 bits, then a clean frame.
    mo_a[0] = 8'hFF; tx_a[0] = 8'h00; p0 = rx_pulses;
    run_frame(1'b0, 1'b0, 1'b0, 1, 5);
    chk("abort_pulses", 32'(rx_pulses - p0), 32'd0);
    mo_a[0] = 8'hC3; tx_a[0] = 8'h5A;
    run_frame(1'b0, 1'b0, 1'b0, 1, 0);
    chk("after_abort_rx", 32'(last_rx), 32'hC3);

    // Reset mid-frame: outputs must drop without a clock edge; ss still low must not restart a frame.
    cpol_i = 1'b0; cphase_i = 1'b0; lsbfe_i = 1'b0; sclk_i = 1'b0;
    tick(6);
    tx_data_i = 8'hFF; tx_load_i = 1'b1;
    tick(1);
    tx_load_i = 1'b0;
    ss_i = 1'b0; mosi_i = 1'b1;
    tick(6);
    for (int i = 0; i < 3; i++) begin
      sclk_i = 1'b1; tick(4);
      sclk_i = 1'b0; tick(4);
    end
    tx_data_i = 8'h55; tx_load_i = 1'b1;
    tick(1);
    tx_load_i = 1'b0;
    tick(2);
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    chk("pre_rst_tx_empty", 32'(tx_empty_o), 32'd0);
    chk("pre_rst_miso", 32'(miso_o), 32'd1);
    p0 = rx_pulses;
    PRESET_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy_o), 32'd0);
    chk("async_tx_empty", 32'(tx_empty_o), 32'd1);
    chk("async_rx_data", 32'(rx_data_o), 32'd0);
    chk("async_rx_valid", 32'(rx_valid_o), 32'd0);
    chk("async_miso", 32'(miso_o), 32'd0);
    chk("async_overrun", 32'(overrun_o), 32'd0);
    tick(2);
    PRESET_n = 1'b1;
    tick(6);
    for (int i = 0; i < 8; i++) begin
      sclk_i = 1'b1; tick(4);
      sclk_i = 1'b0; mosi_i = ~mosi_i; tick(4);
    end
    chk("no_frame_without_fall", 32'(busy_o), 32'd0);
    ss_i = 1'b1;
    tick(8);
    chk("no_rx_after_reset", 32'(rx_pulses - p0), 32'd0);
    exp_ovr = 1'b0;

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      cp = 1'($urandom_range(0, 1)); ch = 1'($urandom_range(0, 1)); lb = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      ab = 0;
      if ($urandom_range(0, 4) == 0) begin
        nb = 1;
        ab = $urandom_range(1, 7);
      end
      for (int k = 0; k < 4; k++) begin
        mo_a[k] = 8'($urandom);
        tx_a[k] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        pulse_clr();
        exp_ovr = 1'b0;
      end
      p0 = rx_pulses;
      run_frame(cp, ch, lb, nb, ab);
      if (ab == 0 && nb >= 2) exp_ovr = exp_ovr | OVR_EN;
      chk("rnd_pulses", 32'(rx_pulses - p0), (ab == 0) ? 32'(nb) : 32'd0);
      chk("rnd_overrun", 32'(overrun_o), 32'(exp_ovr));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchroniser flops on sclk_i, ss_i and mosi_i; legal range 2..3.
REQ-002 PCLK  input  1  system clock; all state is clocked on its rising edge.
REQ-003 PRESET_n  input  1  reset, asynchronous assert, active-low.
REQ-004 sclk_i  input  1  SPI serial clock from master, asynchronous to PCLK.
REQ-005 ss_i  input  1  slave select, active-low, asynchronous.
REQ-006 mosi_i  input  1  serial data from master.
REQ-007 miso_o  output  1  serial data to master; high-impedance control is external.
REQ-008 cpol_i, cphase_i  input  1 each  clock polarity and phase; static while ss_i is low.
REQ-009 lsbfe_i  input  1  1 = LSB first, 0 = MSB first.
REQ-010 tx_data_i  input  8  next byte to transmit.
REQ-011 tx_load_i  input  1  single-cycle write strobe for tx_data_i.
REQ-012 tx_empty_o  output  1  transmit holding register empty.
REQ-013 rx_data_o  output  8  last received byte.
REQ-014 rx_valid_o  output  1  one-PCLK pulse when rx_data_o updates.
REQ-015 busy_o  output  1  frame in progress.
REQ-016 overrun_o  output  1  sticky overrun flag; present only per REQ-030.
REQ-017 ovr_clr_i  input  1  clears overrun_o.

Function
REQ-018 sclk_i, ss_i and mosi_i SHALL pass through SYNC_STAGES flops; the block detects synchronised edges of sclk_i and the falling edge of ss_i; the sclk_i frequency is limited to PCLK/8 or slower.
REQ-019 Sample edge: rising edge of sclk_i when cpol_i == cphase_i, otherwise falling edge; the opposite edge is the shift edge.
REQ-020 FSM states: IDLE, ACTIVE. IDLE to ACTIVE on the synchronised ss_i falling edge. ACTIVE to IDLE on ss_i high, which SHALL be honoured at any bit position.
REQ-021 On entry to ACTIVE, the holding register SHALL move to the shift register and tx_empty_o SHALL be set to 1. If the holding register is already empty, 8'h00 is shifted.
REQ-022 When cphase_i = 0, the first bit SHALL appear on miso_o on the PCLK after the ss_i fall is detected. When cphase_i = 1, the first bit SHALL appear on the first shift edge. Each subsequent shift edge SHALL present the next bit.
REQ-023 The bit order SHALL be MSB-first, or LSB-first when lsbfe_i = 1, and SHALL apply to both directions.
REQ-024 On each sample edge, mosi_i SHALL be shifted in and a 3-bit counter SHALL increment. On the 8th sample, rx_data_o SHALL load on the next PCLK, rx_valid_o SHALL pulse high for one PCLK, the counter SHALL wrap to 0, and the holding register (if full) SHALL reload the shift register for back-to-back bytes.
REQ-025 tx_load_i SHALL be ignored while tx_empty_o = 0. If an ACTIVE-entry or byte-wrap reload coincides with tx_load_i, the reload SHALL take the old content and the new byte SHALL be captured in the same cycle, so tx_empty_o stays 0.
REQ-026 If ss_i rises mid-byte, the partial byte SHALL be discarded, no rx_valid_o is issued, and the counter SHALL clear.
REQ-027 busy_o SHALL equal (state == ACTIVE).

Reset
REQ-028 Assertion of PRESET_n = 0 SHALL asynchronously force the following: state IDLE, counter 0, shift registers 0, rx_data_o 8'h00, rx_valid_o 0, tx_empty_o 1, busy_o 0, overrun_o 0, miso_o 0, and synchroniser flops to ss_i = 1 and sclk_i = cpol-neutral 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame. After deassertion, a new frame SHALL require a fresh ss_i falling edge.

Configuration
REQ-030 Macro SPI_SLAVE_OVERRUN_EN. When defined, overrun_o SHALL set if a byte completes while the previous rx_valid_o byte is unacknowledged (no read tracking: set when a completion occurs within the same frame with rx_data_o unchanged by ovr_clr_i since the last pulse). In that case rx_data_o SHALL still update. The flag SHALL clear on ovr_clr_i, and ovr_clr_i SHALL take priority over a simultaneous set. When the macro is undefined, overrun_o SHALL be tied to 0 and ovr_clr_i SHALL be ignored.

Structure
REQ-031 Shared package spi_pkg SHALL hold the FSM state typedef (IDLE, ACTIVE), the constant SPI_DATA_W = 8, and the edge-select function.
REQ-032 One sub-module, spi_sync_edge, SHALL provide the synchroniser and rise/fall pulse detection. It SHALL be instantiated for sclk_i and ss_i; mosi_i SHALL use synchronisation only.

Verification
REQ-033 Mode 0 (cpol_i = 0, cphase_i = 0), MSB-first, sclk_i = PCLK/8, master sends 8'hA5 with tx 8'h3C loaded -> rx_data_o = 8'hA5 with a single rx_valid_o pulse, and the master captures 8'h3C.
REQ-034 Mode 3 (cpol_i = 1, cphase_i = 1), LSB-first, master sends 8'h81, slave tx 8'h7E -> rx_data_o = 8'h81, and the master sees 8'h7E.
REQ-035 Mode 1, two back-to-back bytes 8'h12 and 8'h34 with 8'hF0 reloaded after the first tx_empty_o -> two rx_valid_o pulses, data 8'h12 then 8'h34, and miso_o sends 8'hF0 on byte 2.
REQ-036 ss_i raised after 5 bits -> no rx_valid_o pulse, busy_o = 0, and the next full frame 8'hC3 is received correctly.
REQ-037 PRESET_n pulsed low mid-frame -> all outputs take their REQ-028 values immediately, without waiting for a PCLK edge.
REQ-038 With SPI_SLAVE_OVERRUN_EN defined, two bytes received without ovr_clr_i -> overrun_o = 1. Asserting ovr_clr_i -> overrun_o = 0. With the macro undefined, overrun_o stays 0.
